ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch stage of the ONC-16 core, directly downstream of the program counter. It takes the current PC value, runs a req/ack read on the instruction memory port, and holds the returned 16-bit word in the instruction register (IR) for the decoder. It pulses `pc_adv` once per accepted instruction so the PC advances, and it discards in-flight or held instructions when a branch is taken.

## Interface
- `DATA_W`, 16 (from `def.v`): instruction and address width.
- `TIMEOUT`, 255: maximum wait cycles for `mem_ack`. Used only with `IFETCH_TIMEOUT_EN`; range 1..255.

Ports:
- `clock` in 1: the single clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_in` in DATA_W: current PC value.
- `pc_adv` out 1: one-cycle pulse; PC increments by 1 on this pulse.
- `flush` in 1: branch taken (the `bre` qualifier); the PC loads its target on the same edge.
- `mem_req` out 1: read request.
- `mem_addr` out DATA_W: registered read address.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in DATA_W: read data.
- `ir` out DATA_W: instruction register.
- `ir_pc` out DATA_W: address `ir` was fetched from.
- `ir_valid` out 1: `ir` holds an instruction.
- `ir_ready` in 1: decoder consumes `ir` when `ir_valid && ir_ready`.
- `fetch_err` out 1: sticky memory timeout flag.

## Operation
States: IDLE, FETCH, FULL, DISCARD.

- **IDLE:** `mem_req`=0. On the next edge, latch `pc_in` into `mem_addr` and go to FETCH, unless `flush` or `fetch_err` is set, in which case stay in IDLE.
- **FETCH:** `mem_req`=1, and `mem_addr` is held stable.
  - `mem_ack` && !`flush`: load `ir`←`mem_rdata`, `ir_pc`←`mem_addr`, set `ir_valid`, pulse `pc_adv`, go to FULL.
  - `mem_ack` && `flush`: drop the data, no `pc_adv`, go to IDLE.
  - !`mem_ack` && `flush`: go to DISCARD.
  - Otherwise stay in FETCH.
- **FULL:** `mem_req`=0.
  - `ir_ready` or `flush`: clear `ir_valid` and go to IDLE. `ir` and `ir_pc` keep their old values.
- **DISCARD:** `mem_req`=1 with the old address. Holding the request until ack is a bus rule. On `mem_ack`, drop the data and go to IDLE. Further `flush` pulses have no extra effect.

Rules:
- `pc_adv` is asserted only on the FETCH→FULL transition.
- A `flush` and a `pc_adv` in the same cycle is impossible, because flush suppresses the load.
- `ir_valid` never rises in the cycle after a flush.
- Addresses wrap naturally at 16 bits; `ifetch` does no arithmetic on them.

## Timing
- Reset values: state=IDLE, `mem_req`=0, `mem_addr`=0, `ir`=0, `ir_pc`=0, `ir_valid`=0, `pc_adv`=0, `fetch_err`=0.
- Reset during FETCH or DISCARD drops `mem_req` on the next cycle. The memory must ignore an abandoned request.
- First `mem_req` is asserted 2 cycles after `rst` deasserts (the IDLE latch cycle, then FETCH).
- Zero-wait memory (ack in the first FETCH cycle): `ir_valid` rises 1 edge after FETCH entry.
- Throughput with `ir_ready` held high: one instruction per 3 cycles (IDLE, FETCH, FULL).
- After `flush`: the first fetch uses the branch target, with `mem_req` asserted 2 cycles after the flush edge, or later if DISCARD is still pending.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
`IFETCH_TIMEOUT_EN`

Defined:
- An 8-bit wait counter clears on FETCH/DISCARD entry and increments each cycle without `mem_ack`.
- When it reaches `TIMEOUT`: set `fetch_err`, drop `mem_req`, and go to IDLE.
- `fetch_err` stays set until `rst`. While it is set, IDLE never leaves.

Undefined:
- There is no counter, and `fetch_err` is tied to 0.

## Structure
- `def.v` gains `IF_STATE_W` (2) and the state encodings `IF_IDLE`, `IF_FETCH`, `IF_FULL`, `IF_DISCARD`. `DATA_W` is reused.
- One natural sub-module: `ifetch_wdt`, the timeout counter, instantiated only under `IFETCH_TIMEOUT_EN`.

## Test plan
- Reset then zero-wait memory returning `16'hA5A5` at `pc_in`=`16'h0000`: `mem_req` at cycle 2, `ir`=`16'hA5A5`, `ir_pc`=0, one `pc_adv` pulse, `ir_valid` held while `ir_ready`=0.
- `mem_ack` delayed by 4 cycles: `mem_addr` is stable for all 5 request cycles, and exactly one `pc_adv` occurs.
- `flush` in FETCH without ack, with `pc_in` changed to `16'h0080`: DISCARD holds the request until ack; the data is dropped; the next fetch `mem_addr`=`16'h0080`; no `pc_adv` for the dropped word.
- `flush` in FULL with `ir_ready`=0: `ir_valid` falls next cycle; the next fetch uses the new `pc_in`=`16'hFFF0`.
- `rst` asserted mid-FETCH: next cycle all outputs are at their reset values, and `mem_req`=0.
- `IFETCH_TIMEOUT_EN`, `TIMEOUT`=8, `mem_ack` never asserted: `fetch_err`=1 after 8 waiting cycles, `mem_req` drops, no further requests until `rst`.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ifetch_pkg -- shared widths and state encoding for the ONC-16 fetch stage.
// Revision 1.0
//------------------------------------------------------------------------------
package ifetch_pkg;

  localparam int DATA_W     = 16;
  localparam int IF_STATE_W = 2;

  typedef enum logic [IF_STATE_W-1:0] {
    IF_IDLE    = 2'd0,
    IF_FETCH   = 2'd1,
    IF_FULL    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_e;

  // States in which a read request is outstanding on the memory port.
  function automatic logic if_bus_busy(input if_state_e s);
    return (s == IF_FETCH) || (s == IF_DISCARD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_wdt.sv
`default_nettype none
//------------------------------------------------------------------------------
// ifetch_wdt -- 8-bit memory-ack wait counter; expire flags the TIMEOUT-th
// consecutive waiting cycle. Revision 1.0
//------------------------------------------------------------------------------
module ifetch_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic expire
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + 8'd1;
    end
  end

  assign expire = run && (count_q == LAST_WAIT);

  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// ifetch -- ONC-16 instruction fetch: req/ack read into IR, flush discard,
// optional ack timeout under IFETCH_TIMEOUT_EN. Revision 1.0
//------------------------------------------------------------------------------
module ifetch
  import ifetch_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_in,
  output logic              pc_adv,
  input  logic              flush,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              fetch_err
);

  if_state_e         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              pc_adv_q, pc_adv_d;
  logic              fetch_err_q, fetch_err_d;
  logic              wdt_expire;

`ifdef IFETCH_TIMEOUT_EN
  logic wdt_run;
  logic wdt_restart;

  // The count restarts on every entry into a requesting state, including FETCH->DISCARD.
  assign wdt_run     = if_bus_busy(state_q) && !mem_ack;
  assign wdt_restart = if_bus_busy(state_d) && (state_d != state_q);

  ifetch_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clock   (clock),
    .rst     (rst),
    .restart (wdt_restart),
    .run     (wdt_run),
    .expire  (wdt_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign wdt_expire     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    pc_adv_d    = 1'b0;
    fetch_err_d = fetch_err_q | wdt_expire;

    case (state_q)
      IF_IDLE: begin
        if (!flush && !fetch_err_q) begin
          mem_addr_d = pc_in;
          state_d    = IF_FETCH;
        end
      end
      IF_FETCH: begin
        if (wdt_expire) begin
          state_d = IF_IDLE;
        end else if (mem_ack && !flush) begin
          ir_d       = mem_rdata;
          ir_pc_d    = mem_addr_q;
          ir_valid_d = 1'b1;
          pc_adv_d   = 1'b1;
          state_d    = IF_FULL;
        end else if (mem_ack) begin
          state_d = IF_IDLE;
        end else if (flush) begin
          state_d = IF_DISCARD;
        end
      end
      IF_FULL: begin
        if (ir_ready || flush) begin
          ir_valid_d = 1'b0;
          state_d    = IF_IDLE;
        end
      end
      IF_DISCARD: begin
        // The abandoned read must still complete on the bus; its data is dropped.
        if (mem_ack || wdt_expire) begin
          state_d = IF_IDLE;
        end
      end
      default: begin
        state_d = IF_IDLE;
      end
    endcase

    mem_req_d = if_bus_busy(state_d);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      pc_adv_q    <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      pc_adv_q    <= pc_adv_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign pc_adv    = pc_adv_q;
  assign fetch_err = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch: memory model with configurable
// ack latency, scoreboard of accepted words, vector table plus corner sequences.
//------------------------------------------------------------------------------
module tb_ifetch;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_in = '0;
  logic        pc_adv;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        fetch_err;

  ifetch #(.TIMEOUT(8)) dut (
    .clock     (clock),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_adv    (pc_adv),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .fetch_err (fetch_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    logic [15:0] pc;
    int          lat;
    int          hold;
    int          exp_req;
    logic [15:0] exp_ir;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[5];

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int wait_cnt = 0;
  int req_cycles = 0;
  int pc_adv_cnt = 0;
  logic        req_flushed = 1'b0;
  logic        addr_held = 1'b0;
  logic [15:0] held_addr = '0;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive the memory response, advance, then score what came out.
  task automatic cycle();
    logic req_now;
    sb_t  e;
    req_now = mem_req;
    if (!req_now) begin
      wait_cnt    = 0;
      req_flushed = 1'b0;
    end
    if (req_now && addr_held) check("addr_stable", mem_addr, held_addr);
    mem_ack   = 1'b0;
    mem_rdata = 16'($urandom);
    if (req_now && wait_cnt >= lat) begin
      mem_ack   = 1'b1;
      mem_rdata = word_at(mem_addr);
      if (!flush && !req_flushed && !rst) sb_q.push_back({mem_addr, word_at(mem_addr)});
    end
    if (req_now && flush) req_flushed = 1'b1;
    if (req_now) req_cycles++;
    held_addr = mem_addr;
    addr_held = req_now && !mem_ack;
    @(posedge clock);
    #1;
    wait_cnt = (req_now && !mem_ack) ? wait_cnt + 1 : 0;
    if (rst) begin
      sb_q.delete();
      addr_held = 1'b0;
    end
    if (pc_adv) begin
      pc_adv_cnt++;
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_ir", ir, e.data);
        check("sb_ir_pc", ir_pc, e.addr);
        check("sb_ir_valid", ir_valid, 1);
      end
    end
  endtask

  task automatic wait_adv(input int bound);
    int n;
    n = 0;
    while (!pc_adv && n < bound) begin
      cycle();
      n++;
    end
    check("adv_seen", pc_adv, 1);
  endtask

  task automatic consume();
    ir_ready = 1'b1;
    cycle();
    check("consume_valid", ir_valid, 0);
    ir_ready = 1'b0;
  endtask

  initial begin
    int adv0;
    int rises[3];
    int nr;
    int n;
    logic prevq;
    logic req_seen;

    vecs[0] = '{16'h0000, 0, 3, 1, 16'hA5A5};
    vecs[1] = '{16'h0123, 4, 1, 5, 16'hA486};
    vecs[2] = '{16'hFFFF, 2, 0, 3, 16'h5A5A};
    vecs[3] = '{16'h1000, 1, 2, 2, 16'hB5A5};
    vecs[4] = '{16'h7F00, 3, 0, 4, 16'hDAA5};

    // Reset values.
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ir", ir, 0);
    check("rst_ir_pc", ir_pc, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_pc_adv", pc_adv, 0);
    check("rst_fetch_err", fetch_err, 0);

    // First request follows the IDLE latch cycle.
    rst   = 1'b0;
    pc_in = vecs[0].pc;
    lat   = vecs[0].lat;
    cycle();
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 0);

    // Vector table: latency, address, hold time before consume.
    for (int i = 0; i < 5; i++) begin
      pc_in      = vecs[i].pc;
      lat        = vecs[i].lat;
      ir_ready   = 1'b0;
      req_cycles = 0;
      adv0       = pc_adv_cnt;
      wait_adv(40);
      check("vec_req_cycles", req_cycles, vecs[i].exp_req);
      check("vec_ir", ir, vecs[i].exp_ir);
      check("vec_ir_pc", ir_pc, vecs[i].pc);
      check("vec_ir_valid", ir_valid, 1);
      for (int h = 0; h < vecs[i].hold; h++) begin
        cycle();
        check("vec_hold_valid", ir_valid, 1);
        check("vec_hold_noadv", pc_adv, 0);
      end
      check("vec_one_adv", pc_adv_cnt - adv0, 1);
      consume();
    end

    // Throughput with ir_ready held high: a new request every 3 cycles.
    ir_ready = 1'b1;
    lat      = 0;
    pc_in    = 16'h2000;
    adv0     = pc_adv_cnt;
    prevq    = mem_req;
    nr       = 0;
    for (int t = 1; t <= 9; t++) begin
      cycle();
      if (mem_req && !prevq && nr < 3) begin
        rises[nr] = t;
        nr++;
      end
      prevq = mem_req;
    end
    ir_ready = 1'b0;
    check("tput_rises", nr, 3);
    check("tput_gap0", rises[1] - rises[0], 3);
    check("tput_gap1", rises[2] - rises[1], 3);
    check("tput_advs", pc_adv_cnt - adv0, 3);

    // Flush in FETCH before ack: DISCARD holds the old address until ack.
    pc_in = 16'h0040;
    lat   = 3;
    adv0  = pc_adv_cnt;
    cycle();
    flush = 1'b1;
    pc_in = 16'h0080;
    cycle();
    flush = 1'b0;
    check("disc_req", mem_req, 1);
    n = 0;
    while (mem_req && n < 20) begin
      check("disc_addr", mem_addr, 16'h0040);
      cycle();
      n++;
    end
    check("disc_cycles", n, 3);
    check("disc_noadv", pc_adv_cnt - adv0, 0);
    check("disc_novalid", ir_valid, 0);
    cycle();
    check("disc_next_req", mem_req, 1);
    check("disc_next_addr", mem_addr, 16'h0080);
    wait_adv(40);
    check("disc_one_adv", pc_adv_cnt - adv0, 1);
    consume();

    // Flush in FULL with the decoder stalled.
    pc_in = 16'h1234;
    lat   = 1;
    cycle();
    wait_adv(40);
    cycle();
    check("full_valid", ir_valid, 1);
    flush = 1'b1;
    pc_in = 16'hFFF0;
    cycle();
    flush = 1'b0;
    check("full_flush_valid", ir_valid, 0);
    check("full_ir_kept", ir, word_at(16'h1234));
    check("full_ir_pc_kept", ir_pc, 16'h1234);
    cycle();
    check("full_next_req", mem_req, 1);
    check("full_next_addr", mem_addr, 16'hFFF0);
    wait_adv(40);
    consume();

    // Reset in the middle of a pending fetch.
    pc_in = 16'h0300;
    lat   = 1000;
    cycle();
    cycle();
    cycle();
    check("mid_req_before", mem_req, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_ir", ir, 0);
    check("mid_rst_ir_pc", ir_pc, 0);
    check("mid_rst_ir_valid", ir_valid, 0);
    check("mid_rst_pc_adv", pc_adv, 0);
    check("mid_rst_fetch_err", fetch_err, 0);

`ifdef IFETCH_TIMEOUT_EN
    // Memory never acks: error after TIMEOUT waiting cycles, then IDLE is sticky.
    pc_in      = 16'h0400;
    lat        = 1000;
    req_cycles = 0;
    cycle();
    n = 0;
    while (mem_req && n < 40) begin
      cycle();
      n++;
    end
    check("to_req_cycles", req_cycles, 8);
    check("to_fetch_err", fetch_err, 1);
    check("to_req_dropped", mem_req, 0);
    req_seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      cycle();
      if (mem_req) req_seen = 1'b1;
    end
    check("to_no_more_req", req_seen, 0);
    check("to_err_sticky", fetch_err, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("to_err_cleared", fetch_err, 0);
`else
    // Without the timeout a long wait simply completes.
    pc_in      = 16'h0400;
    lat        = 20;
    req_cycles = 0;
    req_seen   = 1'b0;
    cycle();
    wait_adv(40);
    check("long_req_cycles", req_cycles, 21);
    check("long_ir", ir, word_at(16'h0400));
    check("long_fetch_err", fetch_err, 0);
    consume();
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
